// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types and constants for the timer/counter unit
package tc_pkg;

    typedef enum logic [1:0] {
        TC_FREE    = 2'd0,
        TC_RELOAD  = 2'd1,
        TC_ONESHOT = 2'd2,
        TC_DOWN    = 2'd3
    } tc_mode_e;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/timer_counter_unit_if.sv
// rtl/timer_counter_unit_if.sv - control/status bundle of the timer/counter unit
interface timer_counter_unit_if #(
    parameter int WIDTH = 16
);
    logic             run;
    logic             gate;
    logic             intx;
    logic             cnt_sel;
    logic             t_in;
    logic [1:0]       mode;
    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic             rld_we;
    logic [WIDTH-1:0] rld_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             ovf_flag;
    logic             ovf_pulse;
    logic             done;

    modport master (
        output run, gate, intx, cnt_sel, t_in, mode, load_en, load_val,
               rld_we, rld_val, ovf_clr,
        input  count, ovf_flag, ovf_pulse, done
    );

    modport slave (
        input  run, gate, intx, cnt_sel, t_in, mode, load_en, load_val,
               rld_we, rld_val, ovf_clr,
        output count, ovf_flag, ovf_pulse, done
    );

endinterface

// File: rtl/tc_input_sync.sv
// rtl/tc_input_sync.sv - two-flop synchroniser with optional falling-edge detect
module tc_input_sync
    import tc_pkg::*;
#(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  hist_q;

    // Resync the pin; flops idle high so a low pin after reset is not seen as a fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
            hist_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign level = sync_q[SYNC_DEPTH-1];
    assign fall  = EDGE_EN ? (hist_q & ~level) : 1'b0;

endmodule

// File: rtl/timer_counter_unit.sv
// rtl/timer_counter_unit.sv - prescaled timer / external-edge counter with reload and overflow
module timer_counter_unit
    import tc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    timer_counter_unit_if.slave  bus
);

    localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [PSC_W-1:0] psc_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] count_next;
    logic             ovf_flag_q;
    logic             ovf_pulse_q;
    logic             done_q;
    logic             intx_s;
    logic             intx_fall_unused;
    logic             t_fall;
    logic             t_level_unused;
    logic             tick_t;
    logic             ev;
    logic             wrap;
    logic             ovf_ev;
    tc_mode_e         mode_s;

    tc_input_sync #(.EDGE_EN(1'b1)) u_t_in_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.t_in),
        .level (t_level_unused),
        .fall  (t_fall)
    );

    tc_input_sync #(.EDGE_EN(1'b0)) u_intx_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.intx),
        .level (intx_s),
        .fall  (intx_fall_unused)
    );

    assign mode_s = tc_mode_e'(bus.mode);
    assign tick_t = (psc_q == PSC_LAST);
    assign ev     = bus.run & (~bus.gate | intx_s) & (bus.cnt_sel ? t_fall : tick_t) & ~done_q;
    assign ovf_ev = ev & wrap & ~bus.load_en;

    // Prescaler free-runs while enabled; only run clears its phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q <= '0;
        end else if (!bus.run || tick_t) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_q + 1'b1;
        end
    end

    // Next count on an event and whether that step is an overflow
    always_comb begin
        count_next = count_q;
        wrap       = 1'b0;
        case (mode_s)
            TC_FREE: begin
                count_next = count_q + 1'b1;
                wrap       = (count_q == ALL_ONES);
            end
            TC_RELOAD, TC_ONESHOT: begin
                if (count_q == ALL_ONES) begin
                    count_next = reload_q;
                    wrap       = 1'b1;
                end else begin
                    count_next = count_q + 1'b1;
                end
            end
            TC_DOWN: begin
                if (count_q == '0) begin
                    count_next = reload_q;
                    wrap       = 1'b1;
                end else begin
                    count_next = count_q - 1'b1;
                end
            end
            default: begin
                count_next = count_q;
                wrap       = 1'b0;
            end
        endcase
    end

    // Count register: a load wins over and discards a coincident event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (bus.load_en) begin
            count_q <= bus.load_val;
        end else if (ev) begin
            count_q <= count_next;
        end
    end

    // Reload register; a reload on the write edge still sees the old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= '0;
        end else if (bus.rld_we) begin
            reload_q <= bus.rld_val;
        end
    end

    // Overflow strobe and sticky flag; a new overflow beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_pulse_q <= 1'b0;
            ovf_flag_q  <= 1'b0;
        end else begin
            ovf_pulse_q <= ovf_ev;
            ovf_flag_q  <= ovf_ev | (ovf_flag_q & ~bus.ovf_clr);
        end
    end

    // One-shot completion halts counting until a load or run drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else if (!bus.run || bus.load_en) begin
            done_q <= 1'b0;
        end else if (ovf_ev && mode_s == TC_ONESHOT) begin
            done_q <= 1'b1;
        end
    end

    assign bus.count     = count_q;
    assign bus.ovf_flag  = ovf_flag_q;
    assign bus.ovf_pulse = ovf_pulse_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_timer_counter_unit.sv
// tb/tb_timer_counter_unit.sv - self-checking bench for timer_counter_unit
module tb_timer_counter_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        gate = 1'b0;
    logic        intx = 1'b1;
    logic        cnt_sel = 1'b0;
    logic        t_in = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        load_en = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic        rld_we = 1'b0;
    logic [15:0] rld_val = 16'h0;
    logic        ovf_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    timer_counter_unit_if #(.WIDTH(16)) ifa ();
    timer_counter_unit_if #(.WIDTH(16)) ifb ();

    assign ifa.run = run;         assign ifb.run = run;
    assign ifa.gate = gate;       assign ifb.gate = gate;
    assign ifa.intx = intx;       assign ifb.intx = intx;
    assign ifa.cnt_sel = cnt_sel; assign ifb.cnt_sel = cnt_sel;
    assign ifa.t_in = t_in;       assign ifb.t_in = t_in;
    assign ifa.mode = mode;       assign ifb.mode = mode;
    assign ifa.load_en = load_en; assign ifb.load_en = load_en;
    assign ifa.load_val = load_val; assign ifb.load_val = load_val;
    assign ifa.rld_we = rld_we;   assign ifb.rld_we = rld_we;
    assign ifa.rld_val = rld_val; assign ifb.rld_val = rld_val;
    assign ifa.ovf_clr = ovf_clr; assign ifb.ovf_clr = ovf_clr;

    timer_counter_unit #(.WIDTH(16), .PRESCALE(12)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    timer_counter_unit #(.WIDTH(16), .PRESCALE(1))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Reference model: behaviour stated as arithmetic on the count value,
    // pin histories as lists of past samples, prescaler as a modulo counter.
    typedef struct packed {
        logic [15:0] count;
        logic [15:0] reload;
        bit          flag;
        bit          pulse;
        bit          done;
        int          psc;
        bit [2:0]    tin_h;   // [0] newest sample of t_in
        bit [1:0]    intx_h;  // [0] newest sample of intx
    } model_t;

    model_t ma, mb;

    function automatic model_t model_reset();
        model_t r;
        r.count = 16'h0; r.reload = 16'h0;
        r.flag = 1'b0; r.pulse = 1'b0; r.done = 1'b0;
        r.psc = 0; r.tin_h = 3'b111; r.intx_h = 2'b11;
        return r;
    endfunction

    function automatic model_t step(model_t m, int ps);
        model_t n;
        bit     fall, tick, ev, ov;
        int     c;
        n    = m;
        c    = int'(m.count);
        fall = m.tin_h[2] && !m.tin_h[1];
        tick = (m.psc == ps - 1);
        ev   = run && (!gate || m.intx_h[1]) && (cnt_sel ? fall : tick) && !m.done;
        ov   = 1'b0;
        n.tin_h  = {m.tin_h[1:0], t_in};
        n.intx_h = {m.intx_h[0], intx};
        n.psc    = run ? (m.psc + 1) % ps : 0;
        if (load_en) begin
            n.count = load_val;
        end else if (ev) begin
            case (mode)
                2'd0: begin
                    ov = (c == 65535);
                    n.count = 16'((c + 1) % 65536);
                end
                2'd1, 2'd2: begin
                    if (c == 65535) begin ov = 1'b1; n.count = m.reload; end
                    else n.count = 16'(c + 1);
                end
                default: begin
                    if (c == 0) begin ov = 1'b1; n.count = m.reload; end
                    else n.count = 16'(c - 1);
                end
            endcase
        end
        if (rld_we) n.reload = rld_val;
        n.pulse = ov;
        n.flag  = ov ? 1'b1 : (ovf_clr ? 1'b0 : m.flag);
        if (!run || load_en) n.done = 1'b0;
        else if (ov && mode == 2'd2) n.done = 1'b1;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= model_reset();
            mb <= model_reset();
        end else begin
            ma <= step(ma, 12);
            mb <= step(mb, 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("a_count_vs_model", ifa.count, ma.count);
        chk("a_flag_vs_model", ifa.ovf_flag, ma.flag);
        chk("a_pulse_vs_model", ifa.ovf_pulse, ma.pulse);
        chk("a_done_vs_model", ifa.done, ma.done);
        chk("b_count_vs_model", ifb.count, mb.count);
        chk("b_flag_vs_model", ifb.ovf_flag, mb.flag);
        chk("b_pulse_vs_model", ifb.ovf_pulse, mb.pulse);
        chk("b_done_vs_model", ifb.done, mb.done);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        run = 1'b0; gate = 1'b0; intx = 1'b1; cnt_sel = 1'b0; t_in = 1'b1;
        mode = 2'd0; load_en = 1'b0; load_val = 16'h0; rld_we = 1'b0;
        rld_val = 16'h0; ovf_clr = 1'b0;
    endtask

    task automatic start_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit          run;
        bit          load_en;
        logic [15:0] load_val;
        logic [1:0]  mode;
        bit          rld_we;
        logic [15:0] rld_val;
        bit          ovf_clr;
        logic [15:0] e_count;
        bit          e_pulse;
        bit          e_flag;
        bit          e_done;
    } vec_t;

    function automatic vec_t mk(bit r, bit le, logic [15:0] lv, logic [1:0] md, bit rw,
                                logic [15:0] rv, bit oc, logic [15:0] ec, bit ep, bit ef, bit ed);
        vec_t v;
        v.run = r; v.load_en = le; v.load_val = lv; v.mode = md; v.rld_we = rw;
        v.rld_val = rv; v.ovf_clr = oc; v.e_count = ec; v.e_pulse = ep;
        v.e_flag = ef; v.e_done = ed;
        return v;
    endfunction

    vec_t tbl [24];

    initial begin
        // Table for the PRESCALE=1 unit: one event per cycle while run=1
        tbl[0]  = mk(1, 1, 16'hFFFE, 2'd0, 0, 16'h0000, 0, 16'hFFFE, 0, 0, 0);
        tbl[1]  = mk(1, 0, 16'h0000, 2'd0, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 0);
        tbl[2]  = mk(1, 0, 16'h0000, 2'd0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0);
        tbl[3]  = mk(1, 0, 16'h0000, 2'd0, 0, 16'h0000, 0, 16'h0001, 0, 1, 0);
        tbl[4]  = mk(1, 0, 16'h0000, 2'd0, 0, 16'h0000, 1, 16'h0002, 0, 0, 0);
        tbl[5]  = mk(1, 1, 16'hFFFF, 2'd1, 1, 16'hFFF0, 0, 16'hFFFF, 0, 0, 0);
        tbl[6]  = mk(1, 0, 16'h0000, 2'd1, 0, 16'h0000, 0, 16'hFFF0, 1, 1, 0);
        tbl[7]  = mk(1, 0, 16'h0000, 2'd1, 0, 16'h0000, 1, 16'hFFF1, 0, 0, 0);
        tbl[8]  = mk(1, 1, 16'h0000, 2'd3, 1, 16'h0005, 0, 16'h0000, 0, 0, 0);
        tbl[9]  = mk(1, 0, 16'h0000, 2'd3, 1, 16'h0009, 0, 16'h0005, 1, 1, 0);
        tbl[10] = mk(1, 0, 16'h0000, 2'd3, 0, 16'h0000, 0, 16'h0004, 0, 1, 0);
        tbl[11] = mk(1, 0, 16'h0000, 2'd3, 0, 16'h0000, 1, 16'h0003, 0, 0, 0);
        tbl[12] = mk(1, 1, 16'h0000, 2'd3, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        tbl[13] = mk(1, 0, 16'h0000, 2'd3, 0, 16'h0000, 0, 16'h0009, 1, 1, 0);
        tbl[14] = mk(1, 1, 16'hFFFF, 2'd2, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 0);
        tbl[15] = mk(1, 0, 16'h0000, 2'd2, 0, 16'h0000, 0, 16'h0009, 1, 1, 1);
        tbl[16] = mk(1, 0, 16'h0000, 2'd2, 0, 16'h0000, 0, 16'h0009, 0, 1, 1);
        tbl[17] = mk(1, 0, 16'h0000, 2'd2, 0, 16'h0000, 1, 16'h0009, 0, 0, 1);
        tbl[18] = mk(1, 1, 16'hFFFF, 2'd2, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 0);
        tbl[19] = mk(1, 1, 16'hFFFF, 2'd2, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 0);
        tbl[20] = mk(1, 0, 16'h0000, 2'd2, 0, 16'h0000, 1, 16'h0009, 1, 1, 1);
        tbl[21] = mk(1, 0, 16'h0000, 2'd0, 0, 16'h0000, 0, 16'h0009, 0, 1, 1);
        tbl[22] = mk(0, 0, 16'h0000, 2'd0, 0, 16'h0000, 0, 16'h0009, 0, 1, 0);
        tbl[23] = mk(1, 0, 16'h0000, 2'd0, 0, 16'h0000, 0, 16'h000A, 0, 1, 0);

        // Reset state
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("rst_a_count", ifa.count, 32'h0);
        chk("rst_a_flag", ifa.ovf_flag, 32'h0);
        chk("rst_a_pulse", ifa.ovf_pulse, 32'h0);
        chk("rst_a_done", ifa.done, 32'h0);
        chk("rst_b_count", ifb.count, 32'h0);

        // Basic timer: 120 clocks at PRESCALE=12 give 10 ticks
        run = 1'b1;
        rst = 1'b0;
        repeat (120) cyc();
        chk("timer_120_count", ifa.count, 32'd10);
        chk("timer_120_flag", ifa.ovf_flag, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_a_count", ifa.count, 32'h0);
        chk("async_rst_b_count", ifb.count, 32'h0);

        // Gate control: two events leak through while the synchronised intx is still high
        start_reset();
        run = 1'b1; gate = 1'b1; intx = 1'b0;
        rst = 1'b0;
        repeat (50) cyc();
        chk("gate_hold_b", ifb.count, 32'd2);
        chk("gate_hold_a", ifa.count, 32'd0);
        intx = 1'b1;
        repeat (2) cyc();
        chk("gate_latency_b", ifb.count, 32'd2);
        cyc();
        chk("gate_resume_b", ifb.count, 32'd3);

        // Counter mode: five falling edges, each low four cycles
        start_reset();
        run = 1'b1; cnt_sel = 1'b1;
        rst = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 5; i++) begin
            t_in = 1'b0;
            repeat (2) cyc();
            chk("cnt_before_b", ifb.count, 32'(i));
            cyc();
            chk("cnt_after_a", ifa.count, 32'(i + 1));
            chk("cnt_after_b", ifb.count, 32'(i + 1));
            cyc();
            t_in = 1'b1;
            repeat (4) cyc();
        end
        chk("cnt_total_a", ifa.count, 32'd5);
        chk("cnt_total_b", ifb.count, 32'd5);

        // Table-driven mode, reload, one-shot and priority vectors
        start_reset();
        run = 1'b1;
        rst = 1'b0;
        foreach (tbl[i]) begin
            run = tbl[i].run; load_en = tbl[i].load_en; load_val = tbl[i].load_val;
            mode = tbl[i].mode; rld_we = tbl[i].rld_we; rld_val = tbl[i].rld_val;
            ovf_clr = tbl[i].ovf_clr;
            cyc();
            chk($sformatf("tbl%0d_count", i), ifb.count, tbl[i].e_count);
            chk($sformatf("tbl%0d_pulse", i), ifb.ovf_pulse, tbl[i].e_pulse);
            chk($sformatf("tbl%0d_flag", i), ifb.ovf_flag, tbl[i].e_flag);
            chk($sformatf("tbl%0d_done", i), ifb.done, tbl[i].e_done);
        end

        // Randomised run against the reference model
        start_reset();
        rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            run     = ($urandom_range(0, 31) != 0);
            gate    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) intx = ~intx;
            if ($urandom_range(0, 2) == 0) t_in = ~t_in;
            if ($urandom_range(0, 15) == 0) cnt_sel = ~cnt_sel;
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            load_en = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       load_val = 16'hFFF8 | 16'($urandom_range(0, 7));
                1:       load_val = 16'($urandom_range(0, 7));
                default: load_val = 16'($urandom);
            endcase
            rld_we  = ($urandom_range(0, 9) == 0);
            rld_val = 16'($urandom);
            ovf_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1;
                chk("rand_rst_a_count", ifa.count, 32'h0);
                chk("rand_rst_b_count", ifb.count, 32'h0);
                rst = 1'b0;
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_counter_unit.md
Name: timer_counter_unit

Overview:
- Parametrised timer/counter, successor to the single-bit gated timer/counter cell.
- Counts either prescaled clk ticks (timer) or falling edges of an external pin (counter).
- Uses the same run/gate/intx qualification, with a WIDTH-bit count, a reload register, four counting modes and overflow signalling.
- Sits beside the interrupt controller; ovf_pulse feeds its request input.

Parameters:
WIDTH, 16, count and reload register width (>=4)
PRESCALE, 12, clk cycles per timer tick (>=1; 1 means tick every cycle)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  counting enable
gate  input  1  1 = counting additionally requires intx high
intx  input  1  external gate pin, asynchronous
cnt_sel  input  1  0 = timer (prescaled clk), 1 = counter (t_in falling edges)
t_in  input  1  external count pin, asynchronous
mode  input  2  0 free-run up, 1 auto-reload up, 2 one-shot up, 3 auto-reload down
load_en  input  1  synchronous load of count from load_val
load_val  input  WIDTH  value for load_en
rld_we  input  1  write reload register
rld_val  input  WIDTH  new reload value
ovf_clr  input  1  clear sticky overflow flag
count  output  WIDTH  current count
ovf_flag  output  1  sticky overflow flag
ovf_pulse  output  1  one-cycle overflow strobe
done  output  1  one-shot completed, counting halted

Behaviour:
- Reset values:
  - count=0, reload=0, ovf_flag=0, ovf_pulse=0, done=0.
  - Prescaler=0, synchroniser flops=1.
- Input synchronisation:
  - intx and t_in each pass through 2 flops.
  - t_in also has a third history flop for edge detection.
  - A t_in fall sampled at edge k is counted at edge k+2, so count changes on the 3rd rising edge after the fall.
  - A change on intx affects qualification at the same latency.
- Prescaler:
  - Counts 0..PRESCALE-1 while run=1; cleared to 0 while run=0.
  - tick_t is asserted in the cycle the prescaler equals PRESCALE-1.
- Event qualification:
  - ev = run & (~gate | intx_s) & (cnt_sel ? t_fall : tick_t) & ~done.
- On ev, by mode:
  - Mode 0: count+1, wrapping all-ones to 0; overflow on the wrap.
  - Mode 1: count+1; at all-ones, count<=reload instead; overflow.
  - Mode 2: as mode 1, and additionally done<=1.
  - Mode 3: count-1; at 0, count<=reload; overflow.
- Overflow:
  - ovf_pulse=1 for exactly the cycle after the overflowing ev edge.
  - ovf_flag is set on the same edge.
  - ovf_flag is cleared by ovf_clr; a simultaneous set beats the clear.
- Load priority:
  - rst > load_en > ev. load_en sets count<=load_val and clears done.
  - A concurrent ev is discarded: no overflow, no pulse.
- done:
  - Also cleared when run=0.
  - While done=1, count holds.
- Reload register:
  - rld_we updates it at the edge.
  - A reload occurring on the same edge uses the old value.
- Mode or cnt_sel change: takes effect on the next ev; count is not altered.
- Prescaler phase is unaffected by gate/intx; only run clears it.
- Reset mid-operation: all state returns to reset values immediately, with no pending event carried over.

Decomposition:
- Package tc_pkg holds:
  - typedef tc_mode_e: TC_FREE=0, TC_RELOAD=1, TC_ONESHOT=2, TC_DOWN=3.
  - Constants for sync depth (2).
- Sub-module tc_input_sync (2-flop synchroniser plus optional falling-edge output).
  - Instantiated twice: t_in with edge output, intx level only.

Test Plan:
- Reset/basic timer:
  - Stimulus: PRESCALE=12, mode 0, run=1, gate=0, cnt_sel=0, 120 clk cycles.
  - Response: count=10, ovf_flag=0. rst asserted mid-run -> count=0 asynchronously.
- Free-run wrap:
  - Stimulus: load_val=FFFE, mode 0, PRESCALE=1.
  - Response: count FFFF then 0000; ovf_pulse high one cycle; ovf_flag stays 1 until ovf_clr.
- Gate control:
  - Stimulus: gate=1, intx=0, run=1, 50 cycles.
  - Response: count unchanged.
  - Stimulus: intx=1.
  - Response: counting resumes 3 cycles later.
- Counter mode:
  - Stimulus: cnt_sel=1, 5 t_in falling edges, each low >=3 cycles.
  - Response: count=5; rising edges do not count.
- Auto-reload and down modes:
  - Mode 1: reload=FFF0, start FFFF -> after the next event count=FFF0, ovf_pulse.
  - Mode 3: reload=0005, count=0 -> count=0005.
  - rld_we to 0009 on the reload edge -> 0005 still used.
- One-shot and priority:
  - Mode 2, overflow -> done=1 and count holds.
  - load_en with a simultaneous event -> count=load_val, done=0, no ovf_pulse.
  - ovf_clr with a simultaneous overflow -> ovf_flag=1.
